// File: rtl/idct_block_ctrl.sv
// Sequencer between the coefficient source and the idct2d core: loads nonzero coefficients,
// fires the core, forwards reconstructed samples tagged with a block index, and owns the quant matrix.
//
// state | meaning
// IDLE  | out of reset, waiting for idct2d to report idle
// LOAD  | accepting coefficient beats; nonzero beats are written to idct2d
// FIRE  | idct_en held until idct2d drops idct_rdy, bounded by FIRE_MAX cycles
// BUSY  | idct2d transforming; result writes forwarded
// DONE  | one-cycle block completion pulse, block index advances
module idct_block_ctrl #(
    parameter int BLK_W    = 8,
    parameter int FIRE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [5:0]        c_addr,
    input  logic [7:0]        c_data,
    input  logic              c_last,
    input  logic              qm_wren,
    input  logic [5:0]        qm_addr,
    input  logic [15:0]       qm_data,
    output logic              qm_ready,
    output logic              idct_en,
    input  logic              idct_rdy,
    output logic [5:0]        idct_iaddr,
    output logic [7:0]        idct_idata,
    output logic              idct_iwren,
    input  logic [5:0]        idct_maddr,
    output logic [15:0]       idct_mq,
    input  logic [5:0]        idct_waddr,
    input  logic [15:0]       idct_wdata,
    input  logic              idct_wwren,
    output logic              o_wren,
    output logic [BLK_W+5:0]  o_addr,
    output logic [15:0]       o_data,
    output logic              blk_done,
    output logic              err
);

    localparam int CNT_W = $clog2(FIRE_MAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, FIRE, BUSY, DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   fire_cnt;
    logic [BLK_W-1:0]   blk_idx;
    logic [BLK_W-1:0]   blk_tag;
    logic               fire_entry;
    logic               fire_tout;
    logic               beat_acc;
    logic [15:0]        qmem [64];

    always_comb begin
        state_nx  = state;
        c_ready   = 1'b0;
        idct_en   = 1'b0;
        blk_done  = 1'b0;
        fire_tout = 1'b0;
        case (state)
            IDLE: if (idct_rdy) state_nx = LOAD;
            LOAD: begin
                c_ready = 1'b1;
                if (c_valid && c_last) state_nx = FIRE;
            end
            FIRE: begin
                idct_en = 1'b1;
                if (!idct_rdy) begin
                    state_nx = BUSY;
                end else if (fire_cnt == '0) begin
                    fire_tout = 1'b1;
                    state_nx  = LOAD;
                end
            end
            BUSY: if (idct_rdy) state_nx = DONE;
            DONE: begin
                blk_done = 1'b1;
                state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
        beat_acc   = c_valid && c_ready;
        fire_entry = (state == LOAD) && (state_nx == FIRE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            fire_cnt <= '0;
            blk_idx  <= '0;
            blk_tag  <= '0;
            err      <= 1'b0;
            qm_ready <= 1'b0;
        end else begin
            state    <= state_nx;
            // registered so it reads 0 while reset is held even though reset lands in IDLE
            qm_ready <= (state_nx == IDLE) || (state_nx == LOAD);
            if (fire_entry) begin
                fire_cnt <= CNT_W'(FIRE_MAX - 1);
                blk_tag  <= blk_idx;
            end else if (state == FIRE && fire_cnt != '0) begin
                fire_cnt <= fire_cnt - CNT_W'(1);
            end
            if (fire_tout) err <= 1'b1;
            if (state == DONE) blk_idx <= blk_idx + BLK_W'(1);
        end
    end

    // zero coefficients are dropped: idct2d clears its store after every block
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idct_iwren <= 1'b0;
            idct_iaddr <= '0;
            idct_idata <= '0;
        end else begin
            idct_iwren <= beat_acc && (c_data != 8'd0);
            if (beat_acc && (c_data != 8'd0)) begin
                idct_iaddr <= c_addr;
                idct_idata <= c_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_wren <= 1'b0;
            o_addr <= '0;
            o_data <= '0;
        end else begin
            o_wren <= idct_wwren;
            if (idct_wwren) begin
                o_addr <= {blk_tag, idct_waddr};
                o_data <= idct_wdata;
            end
        end
    end

    // matrix contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (qm_wren && qm_ready) qmem[qm_addr] <= qm_data;
    end

    assign idct_mq = qmem[idct_maddr];

endmodule

// File: tb/tb_idct_block_ctrl.sv
// Randomized bench for idct_block_ctrl: a transaction-level driver plays the coefficient
// source and idct2d, and scoreboards check every output each cycle against the expected phase.
module tb_idct_block_ctrl;

    localparam int BW = 2;
    localparam int FM = 4;

    logic            clk, reset_n;
    logic            c_valid, c_ready, c_last;
    logic [5:0]      c_addr;
    logic [7:0]      c_data;
    logic            qm_wren, qm_ready;
    logic [5:0]      qm_addr;
    logic [15:0]     qm_data;
    logic            idct_en, idct_rdy, idct_iwren, idct_wwren;
    logic [5:0]      idct_iaddr, idct_maddr, idct_waddr;
    logic [7:0]      idct_idata;
    logic [15:0]     idct_mq, idct_wdata;
    logic            o_wren, blk_done, err;
    logic [BW+5:0]   o_addr;
    logic [15:0]     o_data;

    idct_block_ctrl #(.BLK_W(BW), .FIRE_MAX(FM)) dut (
        .clk(clk), .reset_n(reset_n),
        .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_data(c_data), .c_last(c_last),
        .qm_wren(qm_wren), .qm_addr(qm_addr), .qm_data(qm_data), .qm_ready(qm_ready),
        .idct_en(idct_en), .idct_rdy(idct_rdy),
        .idct_iaddr(idct_iaddr), .idct_idata(idct_idata), .idct_iwren(idct_iwren),
        .idct_maddr(idct_maddr), .idct_mq(idct_mq),
        .idct_waddr(idct_waddr), .idct_wdata(idct_wdata), .idct_wwren(idct_wwren),
        .o_wren(o_wren), .o_addr(o_addr), .o_data(o_data),
        .blk_done(blk_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {P_RST, P_IDLE, P_LOAD, P_FIRE, P_BUSY, P_DONE} phase_t;
    typedef struct {
        logic [5:0]    a;
        logic [15:0]   d;
        logic [BW-1:0] t;
    } item_t;

    phase_t        ph;
    int            vectors, miscompares;
    logic [15:0]   qmodel [64];
    bit            qvalid [64];
    bit            m_err;
    int            blocks;
    logic [BW-1:0] cur_tag;
    bit            qm_rand;
    item_t         iwq[$], owq[$], iw_log[$];
    int            ow_count, done_count;
    logic [BW-1:0] last_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // what the source and the core present at each edge becomes the expectation for the next cycle
    always @(posedge clk) begin
        if (reset_n) begin
            if (ph == P_LOAD && c_valid && c_data != 8'd0)
                iwq.push_back('{a: c_addr, d: {8'd0, c_data}, t: '0});
            if (idct_wwren)
                owq.push_back('{a: idct_waddr, d: idct_wdata, t: cur_tag});
            if (qm_wren && ph == P_LOAD) begin
                qmodel[qm_addr] = qm_data;
                qvalid[qm_addr] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_ctl", {25'd0, c_ready, qm_ready, idct_en, idct_iwren, o_wren, blk_done, err}, 32'd0);
            check("rst_data", {2'd0, idct_iaddr, idct_idata, o_data}, 32'd0);
            check("rst_oaddr", {24'd0, o_addr}, 32'd0);
        end else if (ph != P_RST) begin
            check("c_ready", c_ready, ph == P_LOAD);
            check("qm_ready", qm_ready, ph == P_LOAD);
            check("idct_en", idct_en, ph == P_FIRE);
            check("blk_done", blk_done, ph == P_DONE);
            check("err", err, m_err);
            check("iwren", idct_iwren, iwq.size() > 0);
            if (iwq.size() > 0) begin
                item_t it;
                it = iwq.pop_front();
                if (idct_iwren) check("iaddr_idata", {idct_iaddr, idct_idata}, {it.a, it.d[7:0]});
            end
            check("o_wren", o_wren, owq.size() > 0);
            if (owq.size() > 0) begin
                item_t it;
                it = owq.pop_front();
                if (o_wren) check("o_addr_data", {o_addr, o_data}, {it.t, it.a, it.d});
            end
            if (qvalid[idct_maddr]) check("idct_mq", idct_mq, qmodel[idct_maddr]);
            if (idct_iwren) iw_log.push_back('{a: idct_iaddr, d: {8'd0, idct_idata}, t: '0});
            if (o_wren) begin
                ow_count++;
                last_tag = o_addr[BW+5:6];
            end
            if (blk_done) done_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        idct_maddr = 6'($urandom);
        if (qm_rand) begin
            qm_wren = ($urandom_range(3) == 0);
            qm_addr = 6'($urandom);
            qm_data = 16'($urandom);
        end
    endtask

    task automatic beat(input logic [5:0] a, input logic [7:0] d, input bit last, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(2)) begin
                c_valid = 1'b0;
                c_data  = 8'($urandom);
                c_last  = 1'($urandom);
                tick();
            end
        end
        c_valid = 1'b1;
        c_addr  = a;
        c_data  = d;
        c_last  = last;
        tick();
        c_valid = 1'b0;
        c_last  = 1'b0;
        if (last) begin
            ph      = P_FIRE;
            cur_tag = blocks[BW-1:0];
        end
    endtask

    // d = cycles idct_rdy stays high in FIRE; d >= FM lets the fire time out
    task automatic fire_busy(input int d, input int nwr, input bit dir, input bit poke);
        idct_rdy = 1'b1;
        if (d >= FM) begin
            repeat (FM) tick();
            ph    = P_LOAD;
            m_err = 1'b1;
        end else begin
            repeat (d) tick();
            idct_rdy = 1'b0;
            tick();
            ph = P_BUSY;
            if (poke) begin
                qm_wren = 1'b1;
                qm_addr = 6'd12;
                qm_data = 16'hBEEF;
                tick();
                qm_wren = 1'b0;
            end
            for (int i = 0; i < nwr; i++) begin
                if (!dir) begin
                    repeat ($urandom_range(1)) begin
                        idct_wwren = 1'b0;
                        tick();
                    end
                end
                idct_wwren = 1'b1;
                idct_waddr = dir ? 6'(i) : 6'($urandom);
                idct_wdata = 16'($urandom);
                tick();
            end
            idct_wwren = dir ? 1'b0 : 1'($urandom);
            idct_waddr = 6'($urandom);
            idct_wdata = 16'($urandom);
            idct_rdy   = 1'b1;
            tick();
            ph = P_DONE;
            idct_wwren = dir ? 1'b0 : 1'($urandom);
            idct_waddr = 6'($urandom);
            idct_wdata = 16'($urandom);
            tick();
            ph = P_LOAD;
            blocks++;
            idct_wwren = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        ph         = P_RST;
        iwq.delete();
        owq.delete();
        m_err      = 1'b0;
        blocks     = 0;
        cur_tag    = '0;
        c_valid    = 1'b0;
        c_last     = 1'b0;
        idct_wwren = 1'b0;
        idct_rdy   = 1'b1;
        #1;
        check("async_rst", {28'd0, c_ready, idct_iwren, o_wren, err}, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        ph      = P_IDLE;
        tick();
        ph = P_LOAD;
    endtask

    function automatic logic [7:0] dir_coef(input int a);
        return (a == 0) ? 8'h10 : (a == 9) ? 8'h05 : (a == 63) ? 8'h01 : 8'h00;
    endfunction

    initial begin
        vectors = 0; miscompares = 0; m_err = 1'b0; blocks = 0; cur_tag = '0;
        qm_rand = 1'b0; ow_count = 0; done_count = 0; last_tag = '0;
        c_valid = 1'b0; c_addr = '0; c_data = '0; c_last = 1'b0;
        qm_wren = 1'b0; qm_addr = '0; qm_data = '0;
        idct_rdy = 1'b1; idct_maddr = '0; idct_waddr = '0; idct_wdata = '0; idct_wwren = 1'b0;
        reset_n = 1'b0;
        ph = P_RST;
        repeat (3) tick();
        reset_n = 1'b1;
        ph = P_IDLE;
        tick();
        ph = P_LOAD;
        check("load_after_reset", c_ready, 1'b1);

        qm_wren = 1'b1; qm_addr = 6'd12; qm_data = 16'h1234;
        tick();
        qm_wren = 1'b0;
        idct_maddr = 6'd12;
        #1 check("qm_write_load", idct_mq, 16'h1234);

        iw_log.delete();
        ow_count = 0;
        for (int a = 0; a < 64; a++) beat(6'(a), dir_coef(a), a == 63, 1'b0);
        fire_busy(2, 64, 1'b1, 1'b1);
        check("dir_iw_count", iw_log.size(), 3);
        if (iw_log.size() == 3) begin
            check("dir_iw0", {iw_log[0].a, iw_log[0].d[7:0]}, {6'd0, 8'h10});
            check("dir_iw1", {iw_log[1].a, iw_log[1].d[7:0]}, {6'd9, 8'h05});
            check("dir_iw2", {iw_log[2].a, iw_log[2].d[7:0]}, {6'd63, 8'h01});
        end
        check("dir_ow_count", ow_count, 64);
        check("dir_done_count", done_count, 1);
        check("dir_tag0", last_tag, 2'd0);
        idct_maddr = 6'd12;
        #1 check("qm_busy_ignored", idct_mq, 16'h1234);

        for (int b = 1; b < 5; b++) begin
            beat(6'(b), 8'h33, 1'b1, 1'b0);
            fire_busy(0, 3, 1'b1, 1'b0);
            if (b == 1) check("second_block_tag", last_tag, 2'd1);
        end
        check("fifth_block_tag_wrap", last_tag, 2'd0);
        check("five_done", done_count, 5);

        beat(6'd1, 8'h07, 1'b1, 1'b0);
        fire_busy(FM, 0, 1'b0, 1'b0);
        check("timeout_err", err, 1'b1);
        check("timeout_back_to_load", c_ready, 1'b1);

        qm_rand = 1'b1;
        for (int b = 0; b < 45; b++) begin
            int nb;
            nb = $urandom_range(20, 1);
            if (b % 15 == 14) begin
                for (int i = 0; i < nb; i++)
                    beat(6'($urandom), ($urandom_range(1) == 0) ? 8'd0 : 8'($urandom), 1'b0, 1'b1);
                do_reset();
                check("err_cleared", err, 1'b0);
            end else begin
                for (int i = 0; i < nb; i++)
                    beat(6'($urandom), ($urandom_range(1) == 0) ? 8'd0 : 8'($urandom), i == nb - 1, 1'b1);
                fire_busy($urandom_range(FM), $urandom_range(20), 1'b0, 1'b0);
            end
            if (b == 5) check("err_sticky", err, 1'b1);
        end
        qm_rand = 1'b0;
        qm_wren = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/idct_block_ctrl.md
# idct_block_ctrl

Sequencer sitting between the coefficient source (run-length/VLD stage) and the `idct2d` core in the MPEG2 pipeline. It loads sparse nonzero coefficients for one 8x8 block into `idct2d` and fires it. It waits for completion, then forwards the 64 reconstructed samples to the frame-store writer, tagged with a running block index. It also owns the 64x16 quantiser matrix store that `idct2d` reads through its `maddr`/`mq` port.

## Interface
- `BLK_W`, default 8: width of the block index counter; wraps modulo 2^BLK_W.
- `FIRE_MAX`, default 4: cycles `en` may be held before `idct_rdy` must fall.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `c_valid` in 1: coefficient beat valid.
- `c_ready` out 1: coefficient beat accepted when `c_valid & c_ready`.
- `c_addr` in 6: zig-zag-resolved raster position.
- `c_data` in 8: coefficient value.
- `c_last` in 1: final beat of the block.
- `qm_wren` in 1: quant matrix write strobe.
- `qm_addr` in 6: quant matrix write address.
- `qm_data` in 16: quant matrix write data.
- `qm_ready` out 1: high when matrix writes are honoured.
- `idct_en` out 1: start strobe to `idct2d`.
- `idct_rdy` in 1: `idct2d` idle flag.
- `idct_iaddr` out 6: coefficient load address to `idct2d`.
- `idct_idata` out 8: coefficient load data to `idct2d`.
- `idct_iwren` out 1: coefficient load strobe to `idct2d`.
- `idct_maddr` in 6: matrix read address from `idct2d`.
- `idct_mq` out 16: matrix read data to `idct2d`.
- `idct_waddr` in 6: result write address from `idct2d`.
- `idct_wdata` in 16: result write data from `idct2d`.
- `idct_wwren` in 1: result write strobe from `idct2d`.
- `o_wren` out 1: sample write strobe to the frame-store writer.
- `o_addr` out BLK_W+6: sample address, `{blk_idx, waddr}`.
- `o_data` out 16: sample data.
- `blk_done` out 1: one-cycle pulse per completed block.
- `err` out 1: sticky flag, set when `idct_rdy` fails to fall during FIRE; cleared only by reset.

## Operation
- States and transitions:
  - IDLE: exit to LOAD when `idct_rdy`=1.
  - LOAD: `c_ready`=1. An accepted beat with `c_last`=1 moves to FIRE.
  - FIRE: `idct_en`=1. Moves to BUSY on `idct_rdy`=0. If `idct_rdy` is still 1 after FIRE_MAX cycles, set `err` and return to LOAD.
  - BUSY: `idct_en`=0. Moves to DONE on `idct_rdy`=1.
  - DONE: single cycle; `blk_done`=1, `blk_idx` increments, then return to LOAD.
- Coefficient load:
  - An accepted beat with `c_data`≠0 produces registered `idct_iwren`=1, `idct_iaddr`=`c_addr`, `idct_idata`=`c_data` on the next cycle.
  - Zero beats are accepted and dropped. `idct2d` returns its coefficient store to zero on completion, so only nonzero values are written.
  - Duplicate addresses within a block are written in arrival order, so the last one wins.
  - `c_last` with zero data is still accepted and still ends the block.
- Quant matrix:
  - Internal 64x16 store, read combinationally: `idct_mq`=`qmem[idct_maddr]`.
  - `qm_ready`=1 in IDLE and LOAD only. `qm_wren` is ignored when `qm_ready`=0.
  - The store is not reset; contents persist across reset.
- Output forwarding:
  - `idct_wwren`/`idct_waddr`/`idct_wdata` are registered one cycle to `o_wren`/`o_addr`/`o_data`.
  - The address is tagged with the `blk_idx` captured at FIRE entry. A write arriving on the same edge as `idct_rdy` rising therefore still carries the correct index.
  - Writes while not in BUSY (including DONE) are still forwarded.
- `blk_idx` wraps from 2^BLK_W−1 to 0.

## Timing
- Reset values of outputs: `c_ready`=0, `qm_ready`=0, `idct_en`=0, `idct_iwren`=0, `idct_iaddr`=0, `idct_idata`=0, `o_wren`=0, `o_addr`=0, `o_data`=0, `blk_done`=0, `err`=0.
- Reset values of internal state: state=IDLE, `blk_idx`=0.
- Reset asserted mid-block: all of the above apply immediately (asynchronous). Any partially loaded coefficients in `idct2d` are the core's concern.
- Load path: beat accepted on edge N → `idct_iwren` high during cycle N+1. One beat per cycle sustained.
- The last `idct_iwren` is always issued before or in the same cycle as the first `idct_en`.
- FIRE holds `idct_en` from state entry until `idct_rdy`=0 is sampled. The minimum FIRE duration is 1 cycle.
- Result path latency: `idct_wwren` at edge N → `o_wren` at edge N+1.
- `blk_done` asserts in the cycle after `idct_rdy` is sampled high in BUSY.
- Minimum block-to-block gap: LOAD is re-entered the cycle after DONE.

## Test plan
- Reset with `idct_rdy`=1, then release → LOAD within 2 cycles. All outputs at reset values while `reset_n`=0. `c_ready`=1 in LOAD.
- 64 beats, 3 nonzero (addr 0=0x10, 9=0x05, 63=0x01), `c_last` on addr 63 → exactly 3 `idct_iwren` pulses with matching addr/data, then FIRE. `idct_en` high until model drops `idct_rdy`.
- Model emits 64 writes, then raises `idct_rdy` → 64 `o_wren` pulses with `o_addr`={0,waddr} and data matching. One `blk_done`. A second block's samples are tagged `blk_idx`=1.
- `BLK_W`=2, run 5 blocks → the fifth block's `o_addr`[7:6]=0.
- `qm_wren` to addr 12 = 0x1234 in LOAD → `idct_mq`=0x1234 when `idct_maddr`=12. The same write attempted in BUSY is ignored.
- Model keeps `idct_rdy`=1 through FIRE → `err`=1 after 4 cycles, state back to LOAD. `err` stays set until reset.
